// File: rtl/cci_mpf_prim_heap_arb_pkg.sv
// Shared types and helpers for the heap arbiter slice.
package cci_mpf_prim_heap_arb_pkg;

  localparam int unsigned HEAP_ARB_N_ENTRIES       = 32;
  localparam int unsigned HEAP_ARB_N_CLIENTS       = 4;
  localparam int unsigned HEAP_ARB_MAX_OUTSTANDING = 16;

  typedef logic [$clog2(HEAP_ARB_N_ENTRIES)-1:0]         t_heap_idx;
  typedef logic [$clog2(HEAP_ARB_N_CLIENTS)-1:0]         t_client_idx;
  typedef logic [$clog2(HEAP_ARB_MAX_OUTSTANDING+1)-1:0] t_outstanding_cnt;

  // Priority moves to the client just after the winner.
  function automatic int unsigned rr_next_ptr(input int unsigned winner, input int unsigned n);
    return (winner + 1 >= n) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_arb_rr.sv
// Generic N-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
module cci_mpf_prim_arb_rr
  import cci_mpf_prim_heap_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr_q) + k) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
    end
    ptr_d = found ? PW'(rr_next_ptr(32'(winner), N)) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cci_mpf_prim_heap_arb.sv
// Round-robin alloc/free arbiter with per-client quotas in front of one shared heap.
// Define CCI_MPF_HEAP_ARB_OWNER_CHECK_EN to add an owner table that traps bad frees.
module cci_mpf_prim_heap_arb
  import cci_mpf_prim_heap_arb_pkg::*;
#(
  parameter int unsigned N_ENTRIES       = HEAP_ARB_N_ENTRIES,
  parameter int unsigned N_CLIENTS       = HEAP_ARB_N_CLIENTS,
  parameter int unsigned MAX_OUTSTANDING = HEAP_ARB_MAX_OUTSTANDING,
  localparam int unsigned IDX_W = $clog2(N_ENTRIES),
  localparam int unsigned CLI_W = $clog2(N_CLIENTS),
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CLIENTS-1:0]       allocReq,
  output logic [N_CLIENTS-1:0]       allocGrant,
  output logic [IDX_W-1:0]           allocIdx,
  input  logic [N_CLIENTS-1:0]       freeReq,
  input  logic [N_CLIENTS*IDX_W-1:0] freeIdx,
  output logic [N_CLIENTS-1:0]       freeAck,
  output logic [N_CLIENTS*CNT_W-1:0] outstanding,
  output logic                       heap_enq,
  input  logic                       heap_notFull,
  input  logic [IDX_W-1:0]           heap_allocIdx,
  output logic                       heap_free,
  output logic [IDX_W-1:0]           heap_freeIdx
);

  logic [CNT_W-1:0]     cnt_q [N_CLIENTS];
  logic [N_CLIENTS-1:0] alloc_elig, free_elig;
  logic [CLI_W-1:0]     alloc_winner, free_winner;

  // Eligibility uses registered counts, so a free this cycle cannot lift a full quota.
  always_comb begin
    alloc_elig  = '0;
    free_elig   = '0;
    outstanding = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      alloc_elig[i] = allocReq[i] && (32'(cnt_q[i]) < MAX_OUTSTANDING);
      free_elig[i]  = freeReq[i] && (cnt_q[i] != '0);
      outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  cci_mpf_prim_arb_rr #(.N(N_CLIENTS)) u_alloc_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (alloc_elig),
    .en     (!reset && heap_notFull),
    .grant  (allocGrant),
    .winner (alloc_winner)
  );

  cci_mpf_prim_arb_rr #(.N(N_CLIENTS)) u_free_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (free_elig),
    .en     (!reset),
    .grant  (freeAck),
    .winner (free_winner)
  );

  assign heap_enq     = |allocGrant;
  assign allocIdx     = heap_allocIdx;
  assign heap_free    = |freeAck;
  assign heap_freeIdx = freeIdx[32'(free_winner)*IDX_W +: IDX_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
        if (allocGrant[i] && !freeAck[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        else if (!allocGrant[i] && freeAck[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (!reset && freeReq[i]) begin
        assert (cnt_q[i] != '0)
          else $fatal(1, "heap_arb: client %0d freed with nothing outstanding", i);
      end
    end
  end

`ifdef CCI_MPF_HEAP_ARB_OWNER_CHECK_EN
  logic [N_ENTRIES-1:0] own_valid_q;
  logic [CLI_W-1:0]     own_id_q [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      own_valid_q <= '0;
    end else begin
      if (heap_free) own_valid_q[heap_freeIdx] <= 1'b0;
      if (heap_enq)  own_valid_q[heap_allocIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (heap_enq) own_id_q[heap_allocIdx] <= alloc_winner;
  end

  always_ff @(posedge clk) begin
    if (!reset && heap_free) begin
      assert (own_valid_q[heap_freeIdx] && (own_id_q[heap_freeIdx] == free_winner))
        else $fatal(1, "heap_arb: bad free of idx %0d by client %0d", heap_freeIdx, free_winner);
    end
  end
`endif

endmodule

// File: doc/cci_mpf_prim_heap_arb.md
# cci_mpf_prim_heap_arb

Shares one heap allocator (`cci_mpf_prim_heap_ctrl` or `cci_mpf_prim_heap`) among N_CLIENTS requesters. Allocation and free requests are each arbitrated round-robin, and every client has an outstanding-entry quota so that no single client can drain the heap. It sits between MPF pipeline stages that need scoreboard/tag indices and the single heap instance that owns the storage.

## Interface
- N_ENTRIES, 32, heap entries; must match the attached heap
- N_CLIENTS, 4, number of requesters (≥2)
- MAX_OUTSTANDING, 16, per-client limit on allocated-but-unfreed entries (≤N_ENTRIES)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- allocReq  in  N_CLIENTS  client i requests one entry this cycle
- allocGrant  out  N_CLIENTS  one-hot or zero; client i receives allocIdx this cycle
- allocIdx  out  $clog2(N_ENTRIES)  index granted; valid when |allocGrant
- freeReq  in  N_CLIENTS  client i releases freeIdx[i]
- freeIdx  in  N_CLIENTS×$clog2(N_ENTRIES)  per-client index to release
- freeAck  out  N_CLIENTS  one-hot or zero; freeIdx[i] accepted this cycle
- outstanding  out  N_CLIENTS×$clog2(MAX_OUTSTANDING+1)  per-client allocated count
- heap_enq  out  1  drives heap enq
- heap_notFull  in  1  heap notFull
- heap_allocIdx  in  $clog2(N_ENTRIES)  heap allocIdx
- heap_free  out  1  drives heap free
- heap_freeIdx  out  $clog2(N_ENTRIES)  drives heap freeIdx

## Operation
- Alloc eligibility: allocReq[i] && outstanding[i] < MAX_OUTSTANDING.
- When heap_notFull and ≥1 client is eligible, the highest-priority eligible client is granted; heap_enq = |allocGrant; allocIdx = heap_allocIdx.
- Alloc priority pointer resets to client 0; after a grant to client w it moves to (w+1) mod N_CLIENTS. The pointer is unchanged with no grant.
- Free: one free per cycle is accepted via a separate round-robin pointer (same rules). heap_free = |freeAck; heap_freeIdx = freeIdx[winner].
- Clients hold req until grant/ack. Unacked requests are not lost and not reordered within a client.
- Counters: outstanding[i] +1 on allocGrant[i], −1 on freeAck[i], unchanged when both occur in the same cycle. Width is $clog2(MAX_OUTSTANDING+1), with no wrap.
- freeReq from a client with outstanding==0 is a protocol error: $fatal in simulation, and no freeAck is issued.
- Reset values: allocGrant=0, freeAck=0, heap_enq=0, heap_free=0, outstanding=0, both pointers=0. All grants are forced low while reset is high.
- Reset mid-operation discards all counts. The heap must be reset in the same cycle.

## Timing
- Grant/ack are combinational from req and heap_notFull in the same cycle (zero latency), matching the heap enq/notFull contract.
- Counters and pointers update at the clk edge following the grant/ack.
- An index freed at cycle t is visible to allocation no earlier than the heap's own free-to-alloc latency. The arbiter adds no delay.
- Full: heap_notFull=0 → no allocGrant. Frees still proceed.
- Quota boundary: a client at MAX_OUTSTANDING that frees and requests in the same cycle is not alloc-eligible that cycle. Eligibility uses the registered count.

## Configuration
- CCI_MPF_HEAP_ARB_OWNER_CHECK_EN defined:
  - Keeps an N_ENTRIES owner table (valid bit + client id), written on allocGrant.
  - On freeAck, a $fatal is raised if the entry is not valid (double free) or the owner ≠ the freeing client.
  - The valid bit is cleared on free. All valid bits clear on reset.
- Undefined: no table and no checks; the area is identical to the base arbiter.

## Structure
- Package cci_mpf_prim_heap_arb_pkg holds:
  - t_heap_idx, t_client_idx ($clog2(N_CLIENTS)), t_outstanding_cnt, parameterized through localparam defaults.
  - A function computing the next round-robin pointer.
- Sub-module cci_mpf_prim_arb_rr: a generic N-way round-robin arbiter (request vector, enable, one-hot grant, registered pointer). It is instantiated twice, once for alloc and once for free.

## Test plan
- Reset, then all 4 clients assert allocReq continuously with heap_notFull=1 → grants in order 0,1,2,3,0… with one grant per cycle; each outstanding reaches 4 after 16 cycles.
- MAX_OUTSTANDING=2, client 1 requests alone for 5 cycles with no frees → exactly 2 grants, outstanding[1]=2, and allocGrant stays 0 afterwards.
- Client 0 at outstanding=3, with allocGrant[0] and freeAck[0] in the same cycle → outstanding[0] remains 3.
- Clients 0 and 2 free simultaneously (idx 5, 9) → freeAck[0] with heap_freeIdx=5 in cycle t, then freeAck[2] with heap_freeIdx=9 in cycle t+1.
- heap_notFull=0 for 3 cycles with requests pending → no grants and heap_enq=0. The grant resumes in the first cycle heap_notFull=1, and the pointer is unchanged.
- With OWNER_CHECK_EN: client 1 frees an index granted to client 0 → $fatal. Without the macro: the free is accepted, and outstanding[1] decrements from a nonzero value.
